// File: rtl/lenet_pkg.sv
// Shared types and layer constants for the LeNet-5 datapath sequencers.
package lenet_pkg;

  localparam int L3_NUM_CH      = 16;
  localparam int L3_POOL_STRIDE = 25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } pool3_sched_state_t;

  // Highest base address the channel accumulator ever reaches.
  function automatic int last_base(input int num_ch, input int stride);
    return (num_ch - 1) * stride;
  endfunction

endpackage

// File: rtl/pool3_sched_cycle_watchdog.sv
// Reloadable up-counter that flags the cycle on which LIMIT enabled cycles have elapsed.
module cycle_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturate on the final count so a stalled caller cannot wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && !clear_i && (count_q == LAST);

  if (LIMIT < 1) begin : g_limit_chk
    $error("cycle_watchdog: LIMIT must be at least 1");
  end

endmodule

// File: rtl/pool3_sched.sv
// Layer-3 max-pool channel sequencer: steps the pooler through every feature map.
//   state | meaning
//   IDLE  | waiting for start
//   SETUP | base address presented, cal_en low for one cycle
//   RUN   | cal_en high until pool_done or watchdog expiry
//   GAP   | cal_en low while the pooler clears; waits for pool_done to fall
//   DONE  | one-cycle layer_done pulse
module pool3_sched
  import lenet_pkg::*;
#(
  parameter int NUM_CH         = L3_NUM_CH,
  parameter int CH_STRIDE      = L3_POOL_STRIDE,
  parameter int ADDR_W         = 12,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pool_done,
  output logic              cal_en,
  output logic [ADDR_W-1:0] base_position,
  output logic [4:0]        ch_idx,
  output logic              busy,
  output logic              layer_done,
  output logic              timeout_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]        CH_LAST    = 5'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(CH_STRIDE);

  pool3_sched_state_t state_q, state_d;
  logic [4:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              terr_q, terr_d;
  logic              cal_q, busy_q, done_q;
  logic              run_expired;
  logic              gap_exit;

  cycle_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_run_wdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (state_q != ST_RUN),
    .en_i      (state_q == ST_RUN),
    .expired_o (run_expired)
  );

  // Gap counter saturates, so reaching GAP_LAST means "at least GAP_CYCLES-1".
  assign gap_exit = (gap_q == GAP_LAST) && !pool_done;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    base_d  = base_q;
    terr_d  = terr_q;
    gap_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          ch_d    = '0;
          base_d  = '0;
          terr_d  = 1'b0;
        end
      end
      ST_SETUP: state_d = ST_RUN;
      ST_RUN: begin
        if (pool_done) begin
          state_d = ST_GAP;
        end else if (run_expired) begin
          state_d = ST_DONE;
          terr_d  = 1'b1;
        end
      end
      ST_GAP: begin
        gap_d = (gap_q == GAP_LAST) ? gap_q : gap_q + 1'b1;
        if (gap_exit) begin
          gap_d = '0;
          if (ch_q == CH_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
            ch_d    = ch_q + 1'b1;
            base_d  = base_q + STRIDE_A;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Cancel overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_d = ST_IDLE;
      ch_d    = ch_q;
      base_d  = base_q;
      terr_d  = terr_q;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      base_q  <= '0;
      gap_q   <= '0;
      terr_q  <= 1'b0;
      cal_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      base_q  <= base_d;
      gap_q   <= gap_d;
      terr_q  <= terr_d;
      cal_q   <= (state_d == ST_RUN);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign cal_en        = cal_q;
  assign base_position = base_q;
  assign ch_idx        = ch_q;
  assign busy          = busy_q;
  assign layer_done    = done_q;
  assign timeout_err   = terr_q;

  if (last_base(NUM_CH, CH_STRIDE) >= (1 << ADDR_W)) begin : g_addr_chk
    $error("pool3_sched: ADDR_W too narrow for (NUM_CH-1)*CH_STRIDE");
  end
  if ((NUM_CH < 1) || (NUM_CH > 32)) begin : g_ch_chk
    $error("pool3_sched: NUM_CH must be in 1..32");
  end
  if ((GAP_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_cyc_chk
    $error("pool3_sched: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

endmodule

// File: tb/tb_pool3_sched.sv
// Self-checking bench for pool3_sched: timestamp-based reference model plus directed scenarios.
module tb_pool3_sched;

  localparam int NUM_CH = 16;
  localparam int STRIDE = 25;
  localparam int GAP    = 3;
  localparam int TMO    = 1023;
  localparam int NONE   = -100;

  logic        clk = 1'b0;
  logic        rst, start, abort, pool_done;
  logic        cal_en, busy, layer_done, timeout_err;
  logic [11:0] base_position;
  logic [4:0]  ch_idx;

  pool3_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .pool_done     (pool_done),
    .cal_en        (cal_en),
    .base_position (base_position),
    .ch_idx        (ch_idx),
    .busy          (busy),
    .layer_done    (layer_done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name, input int budget);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not reached within %0d cycles (t=%0t)", name, budget, $time);
  endtask

  // Reference model: expected outputs for the cycle that begins at each rising edge.
  int cyc = 0;
  bit m_busy = 0, m_cal = 0, m_done = 0, m_terr = 0;
  int m_ch = 0, m_base = 0;
  int rise_at = NONE, gap_start = NONE, burst_start = NONE, end_at = NONE;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_done = 1'b0;
    if (rst) begin
      m_busy = 0; m_cal = 0; m_base = 0; m_ch = 0; m_terr = 0;
      rise_at = NONE; gap_start = NONE; burst_start = NONE; end_at = NONE;
    end else if (abort) begin
      if (m_busy) begin
        m_busy = 0; m_cal = 0;
        rise_at = NONE; gap_start = NONE; end_at = NONE;
      end
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_ch = 0; m_base = 0; m_terr = 0;
        rise_at = cyc + 1;
      end
    end else if (end_at == cyc - 1) begin
      m_busy = 0;
      end_at = NONE;
    end else if (m_cal) begin
      if (pool_done) begin
        m_cal = 0;
        gap_start = cyc;
      end else if (cyc - burst_start == TMO) begin
        m_cal = 0; m_terr = 1; m_done = 1;
        end_at = cyc;
      end
    end else if (gap_start != NONE) begin
      if ((cyc - 1 - gap_start >= GAP - 1) && !pool_done) begin
        gap_start = NONE;
        if (m_ch == NUM_CH - 1) begin
          m_done = 1;
          end_at = cyc;
        end else begin
          m_ch = m_ch + 1;
          m_base = m_base + STRIDE;
          rise_at = cyc + 1;
        end
      end
    end else if (rise_at == cyc) begin
      m_cal = 1;
      burst_start = cyc;
      rise_at = NONE;
    end
  end

  // Pooler stand-in configuration.
  int burst_len [NUM_CH];
  int sticky_cfg = 0;
  int never_ch = -1;
  int hi_cnt = 0;
  int sticky_left = 0;

  // Monitor records.
  int  bursts[$];
  int  rise_base[$];
  int  rise_ch[$];
  int  gaps[$];
  int  hi_run = 0, low_cnt = 0, ld_count = 0, rise_with_pd = 0;
  bit  prev_cal = 0, have_fall = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_busy);
      chk("cal_en", cal_en, m_cal);
      chk("base_position", base_position, m_base);
      chk("ch_idx", ch_idx, m_ch);
      chk("layer_done", layer_done, m_done);
      chk("timeout_err", timeout_err, m_terr);
    end
    if (cal_en === 1'b1 && !prev_cal) begin
      rise_base.push_back(int'(base_position));
      rise_ch.push_back(int'(ch_idx));
      if (pool_done) rise_with_pd++;
      if (have_fall) gaps.push_back(low_cnt);
      hi_run = 1;
    end else if (cal_en === 1'b1) begin
      hi_run++;
    end
    if (cal_en !== 1'b1 && prev_cal) begin
      bursts.push_back(hi_run);
      have_fall = 1;
      low_cnt = 1;
    end else if (cal_en !== 1'b1) begin
      low_cnt++;
    end
    if (busy !== 1'b1) have_fall = 0;
    if (layer_done === 1'b1) ld_count++;
    prev_cal = (cal_en === 1'b1);
    if (cal_en === 1'b1) begin
      hi_cnt++;
      sticky_left = sticky_cfg;
      pool_done = (int'(ch_idx) != never_ch) && (hi_cnt >= burst_len[ch_idx[3:0]]);
    end else begin
      hi_cnt = 0;
      if (pool_done && sticky_left > 0) sticky_left--;
      else pool_done = 1'b0;
    end
  end

  task automatic set_burst(input int len);
    for (int k = 0; k < NUM_CH; k++) burst_len[k] = len;
  endtask

  task automatic clear_mon();
    bursts.delete(); rise_base.delete(); rise_ch.delete(); gaps.delete();
    ld_count = 0;
    rise_with_pd = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy === 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (busy === 1'b1) fail_bound(name, budget);
  endtask

  task automatic wait_ch_run(input string name, input int ch, input int budget);
    int i = 0;
    while (!(busy === 1'b1 && cal_en === 1'b1 && int'(ch_idx) == ch) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) fail_bound(name, budget);
  endtask

  task automatic check_full_pass(input string tag, input int blen, input int gap_len);
    chk($sformatf("%s_bursts", tag), bursts.size(), NUM_CH);
    for (int k = 0; k < bursts.size() && k < NUM_CH; k++) begin
      chk($sformatf("%s_len%0d", tag, k), bursts[k], blen);
    end
    for (int k = 0; k < rise_base.size() && k < NUM_CH; k++) begin
      chk($sformatf("%s_base%0d", tag, k), rise_base[k], k * STRIDE);
      chk($sformatf("%s_ch%0d", tag, k), rise_ch[k], k);
    end
    chk($sformatf("%s_gaps", tag), gaps.size(), NUM_CH - 1);
    for (int k = 0; k < gaps.size(); k++) begin
      chk($sformatf("%s_gap%0d", tag, k), gaps[k], gap_len);
    end
    chk($sformatf("%s_layer_done", tag), ld_count, 1);
    chk($sformatf("%s_terr", tag), timeout_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pool_done = 1'b0;
    set_burst(40);
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_cal_en", cal_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_base", base_position, 0);
    chk("rst_ch", ch_idx, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal pass: cal_en bursts of 40, gaps of GAP + one setup cycle.
    clear_mon();
    pulse_start();
    chk("nom_busy_after_start", busy, 1);
    chk("nom_cal_in_setup", cal_en, 0);
    @(negedge clk);
    chk("nom_cal_rise", cal_en, 1);
    wait_idle("nom_wait", 2000);
    check_full_pass("nom", 40, GAP + 1);
    if (rise_base.size() == NUM_CH) chk("nom_last_base", rise_base[NUM_CH-1], 375);
    repeat (5) @(negedge clk);

    // Sticky done: pool_done lingers 5 cycles, gap stretches to 6 plus setup.
    clear_mon();
    set_burst(10);
    sticky_cfg = 5;
    pulse_start();
    wait_idle("sticky_wait", 2000);
    check_full_pass("sticky", 10, 7);
    chk("sticky_rise_with_pd", rise_with_pd, 0);
    sticky_cfg = 0;
    repeat (10) @(negedge clk);

    // Timeout on channel 3.
    clear_mon();
    set_burst(5);
    never_ch = 3;
    pulse_start();
    wait_idle("tmo_wait", 3000);
    chk("tmo_bursts", bursts.size(), 4);
    if (bursts.size() == 4) chk("tmo_len", bursts[3], 1023);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_ch", ch_idx, 3);
    chk("tmo_layer_done", ld_count, 1);
    never_ch = -1;
    repeat (5) @(negedge clk);

    // Start while busy on channel 5 is ignored.
    clear_mon();
    set_burst(20);
    pulse_start();
    wait_ch_run("swb_wait_ch5", 5, 1000);
    pulse_start();
    @(negedge clk);
    chk("swb_ch", ch_idx, 5);
    chk("swb_base", base_position, 125);
    chk("swb_busy", busy, 1);
    wait_idle("swb_wait", 2000);
    chk("swb_bursts", bursts.size(), NUM_CH);
    chk("swb_layer_done", ld_count, 1);
    repeat (5) @(negedge clk);

    // Abort in RUN on channel 7, then a clean restart.
    clear_mon();
    pulse_start();
    wait_ch_run("abt_wait_ch7", 7, 1000);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_cal_en", cal_en, 0);
    chk("abt_busy", busy, 0);
    chk("abt_ch_kept", ch_idx, 7);
    repeat (5) @(negedge clk);
    chk("abt_no_layer_done", ld_count, 0);
    clear_mon();
    pulse_start();
    chk("abt_restart_base", base_position, 0);
    wait_idle("abt_restart_wait", 2000);
    check_full_pass("abt_restart", 20, GAP + 1);
    repeat (5) @(negedge clk);

    // Reset during GAP, then a nominal pass.
    pulse_start();
    wait_ch_run("rgap_wait_ch4", 4, 1000);
    begin
      int i = 0;
      while (cal_en === 1'b1 && i < 100) begin
        @(negedge clk);
        i++;
      end
      if (cal_en === 1'b1) fail_bound("rgap_wait_gap", 100);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rgap_cal_en", cal_en, 0);
    chk("rgap_busy", busy, 0);
    chk("rgap_base", base_position, 0);
    chk("rgap_ch", ch_idx, 0);
    chk("rgap_layer_done", layer_done, 0);
    chk("rgap_terr", timeout_err, 0);
    repeat (3) @(negedge clk);
    clear_mon();
    set_burst(40);
    pulse_start();
    wait_idle("rgap_nom_wait", 2000);
    check_full_pass("rgap_nom", 40, GAP + 1);
    repeat (5) @(negedge clk);

    // Randomized passes: per-channel burst lengths, lingering done, stray starts and aborts.
    for (int p = 0; p < 8; p++) begin
      int i;
      for (int k = 0; k < NUM_CH; k++) burst_len[k] = $urandom_range(1, 30);
      sticky_cfg = $urandom_range(0, 4);
      never_ch = ($urandom_range(0, 5) == 0) ? $urandom_range(0, NUM_CH - 1) : -1;
      pulse_start();
      i = 0;
      while (busy === 1'b1 && i < 4000) begin
        start = ($urandom_range(0, 39) == 0);
        abort = ($urandom_range(0, 599) == 0);
        @(negedge clk);
        i++;
      end
      start = 1'b0;
      abort = 1'b0;
      if (busy === 1'b1) fail_bound("rand_pass", 4000);
      repeat (8) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool3_sched.md
# pool3_sched

Channel sequencer for the layer-3 max-pooling stage of the LeNet-5 datapath. It receives one start pulse per image and walks the pooling unit across all 16 feature maps. For each map it places the map's base address on `base_position`, raises `cal_en` until the pooler reports `pool_done`, then holds `cal_en` low long enough for the pooler's counters to clear. It sits between the top-level layer FSM and the shared conv-3/pool-3 pair, and reports per-layer completion, a watchdog error and the current channel index.

## Interface
- `NUM_CH`, 16: feature maps per layer pass.
- `CH_STRIDE`, 25: address step between maps; a 5×5 pooled map occupies 25 words.
- `ADDR_W`, 12: width of `base_position`.
- `GAP_CYCLES`, 3: minimum number of cycles `cal_en` stays low between maps.
- `TIMEOUT_CYCLES`, 1023: maximum number of `cal_en`-high cycles allowed per map.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to process one layer; accepted only in IDLE.
- `abort`  in  1  synchronous cancel; takes priority over every other input except `rst`.
- `pool_done`  in  1  completion level from the pooler; valid only while `cal_en` is high.
- `cal_en`  out  1  enable to the conv-3/pool-3 pair.
- `base_position`  out  ADDR_W  base write address of the current map.
- `ch_idx`  out  5  current map index, 0..NUM_CH-1.
- `busy`  out  1  high in every state except IDLE.
- `layer_done`  out  1  one-cycle pulse when the layer pass ends.
- `timeout_err`  out  1  sticky flag; cleared when the next `start` is accepted.

## Operation
- All outputs are registered. On reset every output is 0, and the state, channel counter, gap counter and run counter are also 0.
- The state machine has five states: IDLE, SETUP, RUN, GAP, DONE.
  - IDLE: when `start`=1, load `ch_idx`=0, `base_position`=0 and `timeout_err`=0, then go to SETUP. `start` is ignored in every other state.
  - SETUP: lasts one cycle with `cal_en`=0 and `base_position` stable. Always goes to RUN. This cycle lets the pooler register the base address before counting starts.
  - RUN: `cal_en`=1 and the run counter increments each cycle.
    - On `pool_done`=1, go to GAP.
    - If the run counter reaches TIMEOUT_CYCLES with `pool_done` still 0, set `timeout_err`=1 and go to DONE.
  - GAP: `cal_en`=0 and the gap counter increments. Leave GAP only when the counter is at least GAP_CYCLES-1 **and** `pool_done`=0.
    - If `ch_idx`=NUM_CH-1, go to DONE.
    - Otherwise increment `ch_idx`, add CH_STRIDE to `base_position`, clear both counters, and go to SETUP.
  - DONE: `layer_done`=1 for exactly one cycle, then IDLE. `base_position` and `ch_idx` keep their last values.
- `abort` in any non-IDLE state sends the machine to IDLE on the next edge with `cal_en`=0 and `busy`=0. It produces no `layer_done` pulse and does not change `timeout_err`.
- `base_position` is built by accumulation, never by multiplication. The last value is (NUM_CH-1)·CH_STRIDE, which is 375 with the defaults. The accumulator must not wrap for any legal parameter set; an elaboration-time check enforces this.
- `ch_idx` never passes NUM_CH-1.

## Timing
- `start` sampled at edge k gives `busy`=1 at k+1 (SETUP) and `cal_en`=1 at k+2.
- `pool_done` sampled at edge m drops `cal_en` at m+1.
- With `pool_done` already low, the next map's `cal_en` rises at m+1+GAP_CYCLES+1.
- If `pool_done` stays high past the gap, the machine waits in GAP until it falls.
- `layer_done` is high one cycle after the last GAP exit. `busy` drops on the same edge that `layer_done` drops.
- `rst` during RUN brings `cal_en` to 0 at the next edge.
- `abort` and `pool_done` in the same cycle: `abort` wins.

## Structure
- The shared package `lenet_pkg` holds:
  - the state enum `pool3_sched_state_t`;
  - the constants `L3_NUM_CH`=16 and `L3_POOL_STRIDE`=25, which are used as the parameter defaults.
- One sub-module, `cycle_watchdog`: a reloadable counter with `clear`, `en` and an `expired` output, used for the RUN timeout. The GAP counter stays inline.

## Test plan
- **Nominal pass.** The pool model asserts `pool_done` 40 cycles after `cal_en` rises. Pulse `start`. Required: 16 `cal_en` bursts of 40 cycles each; `base_position` steps 0, 25, …, 375; `ch_idx` steps 0..15; exactly one `layer_done`; `timeout_err`=0.
- **Sticky done.** The pool model holds `pool_done` high for 5 cycles after `cal_en` falls. Required: the gap stretches to 6 cycles, and `cal_en` never rises while `pool_done`=1.
- **Timeout.** The pool model never asserts `pool_done` on channel 3. Required: `cal_en` is high for exactly 1023 cycles, then `timeout_err`=1, `layer_done` pulses, and `ch_idx`=3.
- **Start while busy.** Pulse `start` during channel 5. Required: no restart and no change to `ch_idx` or `base_position`.
- **Abort.** Assert `abort` in RUN on channel 7. Required: `cal_en`=0 and `busy`=0 on the next edge, no `layer_done`. A new `start` then restarts at `base_position`=0.
- **Reset mid-GAP.** Assert `rst` for 1 cycle. Required: all outputs are 0 on the next edge, and the following `start` behaves as in the nominal pass.
